// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Purpose:
//   Single-ported arbiter in front of the 4-cycle pipelined main memory. It
//   serves three requesters: the I-cache fill FSM, the D-cache fill FSM and
//   D-cache write-through stores. A fill grant is held until a full line of
//   WORDS_PER_LINE beats has returned. Memory read data and valid are routed
//   only to the granted fill FSM.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   icache_miss/_addr   I-cache fill request (level) and read address
//   dcache_miss/_addr   D-cache fill request (level) and read address
//   dcache_wr_*         write-through store request (level, held to wr_ack)
//   mem_data_out/_valid memory read data and valid
//   mem_addr/enable/wr  memory command
//   mem_data_in         memory write data
//   icache/dcache_grant owner of memory (gates each FSM's miss_detected)
//   *_data_valid        routed read valid for the granted FSM
//   fill_data           read data passthrough, shared by both FSMs
//   wr_ack              one-cycle store-complete pulse
//   arb_busy            arbiter not idle
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_mem_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_mem_addr,
    input  logic              dcache_wr_req,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [DATA_W-1:0] dcache_wr_data,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              icache_grant,
    output logic              dcache_grant,
    output logic              icache_data_valid,
    output logic              dcache_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic              wr_ack,
    output logic              arb_busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IFILL = 2'd1;
    localparam logic [1:0] ST_DFILL = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    localparam int              CNT_W     = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_LINE - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             last_served_q, last_served_d;

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        last_served_d = last_served_q;

        unique case (state_q)
            ST_IDLE: begin
                // Stores go first; with both misses pending, the requester
                // that was not served last wins, so neither can starve.
                if (dcache_wr_req) begin
                    state_d = ST_WRITE;
                end else if (icache_miss && dcache_miss) begin
                    state_d = (last_served_q == SRC_I) ? ST_DFILL : ST_IFILL;
                end else if (dcache_miss) begin
                    state_d = ST_DFILL;
                end else if (icache_miss) begin
                    state_d = ST_IFILL;
                end
            end

            ST_IFILL, ST_DFILL: begin
                // The miss request is deliberately not consulted here: once
                // a fill starts, its beats are already in flight in the
                // memory pipeline and the line must be drained.
                if (mem_data_valid) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d    = '0;
                        last_served_d = (state_q == ST_IFILL) ? SRC_I : SRC_D;
                        state_d       = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            ST_WRITE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            last_served_q <= SRC_I;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            last_served_q <= last_served_d;
        end
    end

    // Outputs are decoded from the state register only, so reset clears
    // them immediately and grants appear one cycle after the request.
    always_comb begin
        mem_addr          = '0;
        mem_enable        = 1'b0;
        mem_wr            = 1'b0;
        mem_data_in       = '0;
        icache_grant      = 1'b0;
        dcache_grant      = 1'b0;
        icache_data_valid = 1'b0;
        dcache_data_valid = 1'b0;
        wr_ack            = 1'b0;

        unique case (state_q)
            ST_IFILL: begin
                icache_grant      = 1'b1;
                mem_addr          = icache_mem_addr;
                mem_enable        = 1'b1;
                icache_data_valid = mem_data_valid;
            end
            ST_DFILL: begin
                dcache_grant      = 1'b1;
                mem_addr          = dcache_mem_addr;
                mem_enable        = 1'b1;
                dcache_data_valid = mem_data_valid;
            end
            ST_WRITE: begin
                mem_addr    = dcache_wr_addr;
                mem_data_in = dcache_wr_data;
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                wr_ack      = 1'b1;
            end
            default: ;
        endcase
    end

    assign fill_data = mem_data_out;
    assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Single-ported arbiter between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores, in front of the 4-cycle pipelined main memory.
- Grants memory to one requester at a time and holds a fill grant until a full 8-word line has returned.
- Routes memory read data and valid back to the granted fill FSM only.
- Produces the grant that gates each fill FSM's miss_detected input.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- WORDS_PER_LINE, 8, valid beats per cache line fill

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- icache_miss  in  1  I-cache fill request (level, held until serviced)
- icache_mem_addr  in  ADDR_W  read address from I-cache fill FSM
- dcache_miss  in  1  D-cache fill request (level)
- dcache_mem_addr  in  ADDR_W  read address from D-cache fill FSM
- dcache_wr_req  in  1  write-through store request (level, held until wr_ack)
- dcache_wr_addr  in  ADDR_W  store address
- dcache_wr_data  in  DATA_W  store data
- mem_data_out  in  DATA_W  memory read data
- mem_data_valid  in  1  memory read data valid
- mem_addr  out  ADDR_W  memory address
- mem_enable  out  1  memory access enable
- mem_wr  out  1  memory write enable
- mem_data_in  out  DATA_W  memory write data
- icache_grant  out  1  I-cache fill FSM owns memory
- dcache_grant  out  1  D-cache fill FSM owns memory
- icache_data_valid  out  1  routed valid to I-cache FSM
- dcache_data_valid  out  1  routed valid to D-cache FSM
- fill_data  out  DATA_W  mem_data_out passthrough, shared by both FSMs
- wr_ack  out  1  one-cycle store-complete pulse
- arb_busy  out  1  state != IDLE

Behaviour:
- States: IDLE, IFILL, DFILL, WRITE. 2-bit state register with asynchronous clear to IDLE.
- Also on reset: beat_cnt = 0, last_served = I (so D wins the first read tie).
- Reset outputs: mem_addr 0, mem_enable 0, mem_wr 0, mem_data_in 0, both grants 0, both data_valids 0, wr_ack 0, arb_busy 0.
- IDLE priority, evaluated each cycle:
  - dcache_wr_req -> WRITE.
  - Else, if both misses are pending, go to the requester not equal to last_served.
  - Else, go to whichever single miss is pending.
  - A decision takes effect at the next clock edge; grants are state-decoded, so the first grant is visible 1 cycle after the request.
- IFILL / DFILL:
  - The matching grant is high.
  - mem_addr = that FSM's mem_addr; mem_enable = 1; mem_wr = 0.
  - X_data_valid = mem_data_valid; the other data_valid = 0.
  - beat_cnt increments on each mem_data_valid.
  - On the valid beat with beat_cnt == WORDS_PER_LINE-1: clear beat_cnt, set last_served to this requester, return to IDLE.
  - The grant drops in the cycle after the last beat.
- WRITE (exactly 1 cycle):
  - mem_addr = dcache_wr_addr, mem_data_in = dcache_wr_data, mem_enable = 1, mem_wr = 1, wr_ack = 1.
  - Returns to IDLE; last_served is unchanged.
- In IDLE: mem_enable = 0, mem_addr = 0.
- Boundary conditions:
  - mem_data_valid in IDLE or WRITE is ignored: no data_valid, no count change.
  - A requester dropping its miss mid-fill does not abort; the line completes, because memory is pipelined and data is already in flight.
  - A store arriving during a fill waits; it is served in the IDLE cycle right after the fill, ahead of any pending miss.
  - Back-to-back fills always pass through one IDLE cycle.
  - beat_cnt is width clog2(WORDS_PER_LINE) and never wraps past WORDS_PER_LINE-1.
  - Reset asserted mid-fill or mid-write: immediate IDLE, all outputs at reset values, partial count discarded.

Test Plan:
- I-miss only, addr 0x1230; memory returns 8 valids at cycles 5..12 -> icache_grant high cycles 1..12; icache_data_valid mirrors valid; dcache_data_valid stays 0; grant low at cycle 13.
- icache_miss, dcache_miss and dcache_wr_req (addr 0x0040, data 0xBEEF) rise together from reset -> WRITE first with mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF, wr_ack pulse. Then DFILL, because last_served=I at reset. Then IFILL.
- Both misses held continuously through 4 fills -> grant order D, I, D, I, with one IDLE cycle between each fill.
- dcache_wr_req raised during beat 3 of an IFILL -> no mem_wr until IFILL completes; wr_ack exactly 1 cycle after the return to IDLE; store has priority over a concurrently pending dcache_miss.
- Spurious mem_data_valid in IDLE, then a D-fill -> no routed valid in IDLE; the D-fill still needs exactly 8 beats.
- rst_n pulsed low after 4 beats of a DFILL -> outputs cleared asynchronously; a new dcache_miss needs a full 8 beats to finish.
